event_order_sequencer: RTL
==========================

Name: event_order_sequencer

Overview:
- Multi-channel, synthesizable event serializer that issues same-cycle events in a deterministic order.
- Each channel marked deferred in DEFER_MASK always issues after every non-deferred event carrying the same timestamp. This is the hardware analogue of pushing a statement to a later scheduling region.
- Sits between event producers and a single-consumer log/trace port; one event per cycle on a valid/ready output.

Parameters:
- NUM_CH, 4: number of input channels (2..16).
- TS_W, 16: timestamp counter width.
- DEFER_MASK, {NUM_CH{1'b0}}: bit i=1 marks channel i as deferred.
- RR_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin among equal-rank candidates.

Ports:
- clk, in, 1: single clock; all logic on posedge.
- rst, in, 1: synchronous, active-high reset.
- ev_in, in, NUM_CH: per-channel event strobe, one event per high cycle.
- out_valid, out, 1: selected event available.
- out_ready, in, 1: consumer accepts; pop when out_valid && out_ready.
- out_ch, out, $clog2(NUM_CH): channel index of the selected event.
- out_ts, out, TS_W: timestamp captured with the event.
- out_deferred, out, 1: selected channel is deferred.
- now_ts, out, TS_W: free-running timestamp counter.
- overflow, out, NUM_CH: sticky per-channel drop flag.

Behaviour:
- Reset (rst high at posedge) clears:
  - all pending bits, overflow, and the RR pointer;
  - now_ts to 0.
- While reset is active: out_valid=0, out_ch=0, out_ts=0, out_deferred=0.
- Reset mid-operation discards all pending events silently and does not set overflow.
- now_ts increments by 1 every cycle after reset and wraps modulo 2^TS_W.
- Per-channel storage holds one slot: a pending bit plus ts_q[i].
- Capture: if ev_in[i]=1 at a posedge with slot i free, or with slot i being popped that same cycle, then:
  - pending[i] is set;
  - ts_q[i] takes the pre-increment now_ts value.
- Drop: if ev_in[i]=1 while pending[i]=1 and slot i is not popped that cycle, the event is dropped and overflow[i] is set sticky. overflow clears only on reset.
- Latency: an event captured at the posedge ending cycle t is presentable in cycle t+1 at the earliest.
- out_valid is OR of pending; outputs are combinational from registered state only (no combinational path from ev_in).
- Selection among pending channels, applied in order:
  1. Largest age, where age = now_ts - ts_q[i] computed modulo 2^TS_W (oldest first).
  2. On equal age, non-deferred before deferred.
  3. On remaining ties:
     - RR_MODE=0: lowest index.
     - RR_MODE=1: first index at or after rr_ptr, wrapping.
- Pop clears pending[out_ch]. In RR_MODE=1, rr_ptr becomes out_ch+1 modulo NUM_CH; the pointer moves only on pop.
- Stability: while out_valid=1 && out_ready=0, out_ch, out_ts and out_deferred hold. New captures always carry a strictly younger timestamp and cannot preempt.
- Correct ordering requires every event to be popped within 2^(TS_W-1)-1 cycles of capture. Behaviour beyond that bound is unspecified.
- Simultaneous pop of channel i and ev_in[i]=1: the old event issues and the new event is captured with no overflow.

Test Plan:
- Simultaneous events with a deferred channel:
  - Setup: NUM_CH=4, DEFER_MASK=4'b0001, RR_MODE=0, out_ready=1, ev_in=4'b1111 at now_ts=5.
  - Required: pops in consecutive cycles in order ch1, ch2, ch3, ch0, all with out_ts=5; out_deferred=1 only on ch0.
- Oldest first across timestamps:
  - Setup: ev_in[3] at now_ts=2, ev_in[0] at now_ts=4, out_ready=0 until now_ts=8.
  - Required: ch3/ts=2 issues first, then ch0/ts=4.
  - Required: out_ch=3 and out_ts=2 are held constant during the stall.
- Overflow:
  - Setup: out_ready=0, ev_in[2] pulsed at now_ts=10 and again at now_ts=11.
  - Required: overflow=4'b0100; the single issued event is ch2/ts=10.
  - Required: pulsing ev_in[2] on the same cycle as its pop sets no further overflow, and the new event issues next.
- Round-robin fairness:
  - Setup: RR_MODE=1, DEFER_MASK=0; all four channels re-fire on every pop cycle, out_ready=1.
  - Required: across 8 pops out_ch cycles 0,1,2,3,0,1,2,3.
  - Required: with RR_MODE=0, the oldest-first rule still rotates service, and no channel waits more than NUM_CH pops.
- Timestamp wrap:
  - Setup: TS_W=4; ev_in[1] at now_ts=15, ev_in[0] at now_ts=0 (wrapped), out_ready=0 for 3 cycles.
  - Required: ch1/ts=15 issues before ch0/ts=0.
- Reset mid-operation:
  - Setup: 3 pending events, overflow[1] set, rst asserted for 1 cycle.
  - Required: next cycle out_valid=0, overflow=0, now_ts=0.
  - Required: an event after reset issues with ts relative to the new count.

Source files
------------

// File: rtl/event_order_sequencer.sv
// Serializes per-channel event strobes onto one valid/ready port,
// oldest timestamp first, non-deferred before deferred on equal age.
//
// Ports:
//   clk          : clock, all state on posedge
//   rst          : synchronous active-high reset
//   ev_in        : per-channel event strobe (one event per high cycle)
//   out_valid    : an event is presented
//   out_ready    : consumer accepts; pop on out_valid && out_ready
//   out_ch       : channel of the presented event
//   out_ts       : timestamp captured with the presented event
//   out_deferred : presented channel is a deferred channel
//   now_ts       : free-running timestamp counter
//   overflow     : sticky per-channel drop flags
module event_order_sequencer #(
  parameter int                NUM_CH     = 4,
  parameter int                TS_W       = 16,
  parameter logic [NUM_CH-1:0] DEFER_MASK = '0,
  parameter bit                RR_MODE    = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         ev_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic [TS_W-1:0]           out_ts,
  output logic                      out_deferred,
  output logic [TS_W-1:0]           now_ts,
  output logic [NUM_CH-1:0]         overflow
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] pending;
  logic [TS_W-1:0]   ts_q [NUM_CH];
  logic [CH_W-1:0]   rr_ptr;

  logic [CH_W-1:0]   start;
  logic [CH_W:0]     idx;
  logic [TS_W-1:0]   age;
  logic              cand_def;
  logic              sel_found;
  logic [CH_W-1:0]   sel_ch;
  logic [TS_W-1:0]   sel_age;
  logic [TS_W-1:0]   sel_ts;
  logic              sel_def;
  logic              pop;
  logic [NUM_CH-1:0] pop_vec;

  // Scan starts at the RR pointer (or 0), so only a strictly better
  // candidate replaces the current one and ties go to scan order.
  always_comb begin
    start     = RR_MODE ? rr_ptr : '0;
    idx       = '0;
    age       = '0;
    cand_def  = 1'b0;
    sel_found = 1'b0;
    sel_ch    = '0;
    sel_age   = '0;
    sel_ts    = '0;
    sel_def   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = {1'b0, start} + (CH_W+1)'(k);
      if (idx >= (CH_W+1)'(NUM_CH))
        idx = idx - (CH_W+1)'(NUM_CH);
      // Modular age keeps ordering correct across counter wrap.
      age      = now_ts - ts_q[idx[CH_W-1:0]];
      cand_def = DEFER_MASK[idx[CH_W-1:0]];
      if (pending[idx[CH_W-1:0]]) begin
        if (!sel_found || age > sel_age ||
            (age == sel_age && sel_def && !cand_def)) begin
          sel_found = 1'b1;
          sel_ch    = idx[CH_W-1:0];
          sel_age   = age;
          sel_ts    = ts_q[idx[CH_W-1:0]];
          sel_def   = cand_def;
        end
      end
    end
  end

  assign out_valid    = !rst && (|pending);
  assign out_ch       = out_valid ? sel_ch  : '0;
  assign out_ts       = out_valid ? sel_ts  : '0;
  assign out_deferred = out_valid ? sel_def : 1'b0;
  assign pop          = out_valid && out_ready;

  always_comb begin
    pop_vec = '0;
    if (pop)
      pop_vec[sel_ch] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      overflow <= '0;
      rr_ptr   <= '0;
      now_ts   <= '0;
      for (int i = 0; i < NUM_CH; i++)
        ts_q[i] <= '0;
    end else begin
      now_ts <= now_ts + TS_W'(1);
      for (int i = 0; i < NUM_CH; i++) begin
        // A slot being popped this cycle is free for a new capture.
        if (ev_in[i] && (!pending[i] || pop_vec[i])) begin
          pending[i] <= 1'b1;
          ts_q[i]    <= now_ts;
        end else if (ev_in[i]) begin
          overflow[i] <= 1'b1;
        end else if (pop_vec[i]) begin
          pending[i] <= 1'b0;
        end
      end
      if (pop && RR_MODE) begin
        if (sel_ch == CH_W'(NUM_CH-1))
          rr_ptr <= '0;
        else
          rr_ptr <= sel_ch + CH_W'(1);
      end
    end
  end

endmodule
